// File: rtl/skeleton_pass_controller.sv
// Iterative thinning pass sequencer: streams the frame RAM into the convolution unit, writes the
// returned pixels back and repeats until two zero-removal passes in a row or the pass limit.
module skeleton_pass_controller #(
  parameter int unsigned N         = 8,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned PIXEL_W   = 8,
  parameter int unsigned CU_STRIDE = 2,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         max_iter,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic               error,
  output logic [7:0]         iter_count,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_re,
  input  logic [PIXEL_W-1:0] ram_rdata,
  output logic               ram_we,
  output logic [PIXEL_W-1:0] ram_wdata,
  output logic               cu_we,
  output logic [PIXEL_W-1:0] cu_data_in,
  output logic               cu_phase,
  input  logic               cu_write_out_enable,
  input  logic [ADDR_W-1:0]  cu_address,
  input  logic [PIXEL_W-1:0] cu_output
);

  localparam int unsigned NumPix = N * N;
  localparam int unsigned SubW   = (CU_STRIDE > 1) ? $clog2(CU_STRIDE) : 1;
  localparam int unsigned ToW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CntW   = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(NumPix - 1);
  localparam logic [SubW-1:0]   LastSub  = SubW'(CU_STRIDE - 1);
  localparam logic [ToW-1:0]    LastTo   = ToW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StWaitOut, StWriteback, StCheck, StDone
  } state_e;

  state_e             state_q;
  logic               busy_q, done_q, converged_q, error_q, cu_phase_q, zero_pass_q;
  logic [7:0]         iter_q;
  logic [ADDR_W-1:0]  ram_addr_q, last_addr_q;
  logic               ram_re_q, ram_we_q;
  logic [PIXEL_W-1:0] ram_wdata_q, cu_hold_q;
  logic               rd_active_q, cu_we_q, cu_first_q;
  logic [SubW-1:0]    sub_q;
  logic [ToW-1:0]     to_q;
  logic [CntW-1:0]    load_cnt_q, ret_cnt_q;

  logic            wb_fire, check_conv, check_stop, enter_load;
  logic [CntW-1:0] removed;
  logic [7:0]      iter_inc, max_eff;

  always_comb begin
    // The WAIT_OUT cycle in which write-out starts already carries the first returned pixel.
    wb_fire    = cu_write_out_enable && (cu_address != last_addr_q) &&
                 ((state_q == StWaitOut) || (state_q == StWriteback));
    removed    = (ret_cnt_q > load_cnt_q) ? '0 : (load_cnt_q - ret_cnt_q);
    iter_inc   = (iter_q == 8'hFF) ? iter_q : (iter_q + 8'd1);
    max_eff    = (max_iter == 8'd0) ? 8'd1 : max_iter;
    check_conv = (removed == '0) && zero_pass_q;
    check_stop = check_conv || (iter_inc >= max_eff);
    enter_load = (((state_q == StIdle) || (state_q == StDone)) && start) ||
                 ((state_q == StCheck) && !check_stop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      converged_q <= 1'b0;
      error_q     <= 1'b0;
      cu_phase_q  <= 1'b0;
      zero_pass_q <= 1'b0;
      iter_q      <= '0;
      ram_addr_q  <= '0;
      last_addr_q <= '1;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cu_hold_q   <= '0;
      rd_active_q <= 1'b0;
      cu_we_q     <= 1'b0;
      cu_first_q  <= 1'b0;
      sub_q       <= '0;
      to_q        <= '0;
      load_cnt_q  <= '0;
      ret_cnt_q   <= '0;
    end else begin
      ram_we_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
            error_q     <= 1'b0;
            iter_q      <= '0;
            zero_pass_q <= 1'b0;
            cu_phase_q  <= 1'b0;
          end
        end
        StLoad: begin
          // CU side trails the RAM read side by exactly one cycle.
          cu_we_q    <= rd_active_q;
          cu_first_q <= ram_re_q;
          if (cu_first_q) begin
            cu_hold_q <= ram_rdata;
            if (ram_rdata != '0) load_cnt_q <= load_cnt_q + 1'b1;
          end
          if (rd_active_q) begin
            if (sub_q == LastSub) begin
              sub_q <= '0;
              if (ram_addr_q == LastWord) begin
                rd_active_q <= 1'b0;
                ram_re_q    <= 1'b0;
              end else begin
                ram_addr_q <= ram_addr_q + 1'b1;
                ram_re_q   <= 1'b1;
              end
            end else begin
              sub_q    <= sub_q + 1'b1;
              ram_re_q <= 1'b0;
            end
          end else begin
            state_q <= StWaitOut;
            to_q    <= '0;
          end
        end
        StWaitOut: begin
          if (cu_write_out_enable) begin
            state_q <= StWriteback;
          end else if (to_q == LastTo) begin
            state_q     <= StDone;
            error_q     <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            converged_q <= 1'b0;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StWriteback: begin
          if (!cu_write_out_enable) state_q <= StCheck;
        end
        StCheck: begin
          iter_q      <= iter_inc;
          cu_phase_q  <= ~cu_phase_q;
          zero_pass_q <= (removed == '0);
          if (check_stop) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            converged_q <= check_conv;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (wb_fire) begin
        ram_we_q    <= 1'b1;
        ram_addr_q  <= cu_address;
        ram_wdata_q <= cu_output;
        last_addr_q <= cu_address;
        if (cu_output != '0) ret_cnt_q <= ret_cnt_q + 1'b1;
      end

      if (enter_load) begin
        state_q     <= StLoad;
        ram_re_q    <= 1'b1;
        ram_addr_q  <= '0;
        sub_q       <= '0;
        rd_active_q <= 1'b1;
        cu_we_q     <= 1'b0;
        cu_first_q  <= 1'b0;
        load_cnt_q  <= '0;
        ret_cnt_q   <= '0;
        last_addr_q <= '1;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = converged_q;
  assign error      = error_q;
  assign iter_count = iter_q;
  assign ram_addr   = ram_addr_q;
  assign ram_re     = ram_re_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign cu_we      = cu_we_q;
  assign cu_phase   = cu_phase_q;
  // First stride cycle forwards the RAM's registered read data; later cycles replay the copy.
  assign cu_data_in = !cu_we_q ? '0 : (cu_first_q ? ram_rdata : cu_hold_q);

endmodule

// File: doc/skeleton_pass_controller.md
Name: skeleton_pass_controller

Overview:
- Sequences iterative thinning passes over one N x N frame held in the frame RAM.
- Each pass: stream the frame into the convolution unit, wait for its write-out phase, write the returned pixels back to the frame RAM, and count removed pixels.
- Alternates sub-iteration phase every pass.
- Stops when two consecutive passes remove nothing (converged) or the iteration limit is hit.

Parameters:
- N, 8, frame side length in pixels.
- ADDR_W, 7, frame address width; must hold N*N-1.
- PIXEL_W, 8, pixel width.
- CU_STRIDE, 2, clock cycles per word accepted by the convolution unit.
- TIMEOUT, 1024, max cycles to wait in WAIT_OUT for the write-out phase.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, begin processing; sampled only in IDLE/DONE.
- max_iter, input, 8, pass limit; 0 treated as 1.
- busy, output, 1, high from start acceptance until DONE.
- done, output, 1, level; high in DONE until next accepted start.
- converged, output, 1, valid with done; 1 = stopped on two zero-removal passes.
- error, output, 1, valid with done; 1 = write-out timeout.
- iter_count, output, 8, passes completed.
- ram_addr, output, ADDR_W, frame RAM address.
- ram_re, output, 1, frame RAM read strobe; data returns next cycle.
- ram_rdata, input, PIXEL_W, frame RAM read data.
- ram_we, output, 1, frame RAM write strobe.
- ram_wdata, output, PIXEL_W, frame RAM write data.
- cu_we, output, 1, load enable to the convolution unit.
- cu_data_in, output, PIXEL_W, pixel to the convolution unit.
- cu_phase, output, 1, sub-iteration select; 0 on even passes, 1 on odd passes.
- cu_write_out_enable, input, 1, convolution unit is returning results.
- cu_address, input, ADDR_W, address of the returned pixel.
- cu_output, input, PIXEL_W, returned pixel.

Behaviour:
- Reset (any time, including mid-pass):
  - State goes to IDLE.
  - All outputs go to 0: busy, done, converged, error, iter_count, ram_*, cu_*.
  - All counters clear.
- States: IDLE, LOAD, WAIT_OUT, WRITEBACK, CHECK, DONE.
- IDLE/DONE:
  - start=1 moves to LOAD the next cycle.
  - Clears done, converged, error, iter_count and the zero-pass flag.
  - Sets busy.
- start while busy: ignored.
- LOAD:
  - Address counter a runs 0..N*N-1.
  - Each word occupies CU_STRIDE cycles:
    - ram_re=1, ram_addr=a in the first cycle of the stride.
    - cu_we=1 and cu_data_in = registered ram_rdata for all CU_STRIDE cycles starting one cycle later. This gives a 1-cycle pipeline skew.
  - load_cnt increments for each loaded pixel that is nonzero.
  - After the last word's stride, cu_we drops and the controller moves to WAIT_OUT.
  - Total LOAD length = N*N*CU_STRIDE+1 cycles.
- WAIT_OUT:
  - Timeout counter runs.
  - cu_write_out_enable=1 moves to WRITEBACK.
  - Counter reaching TIMEOUT-1 sets error=1 and moves to DONE with converged=0.
- WRITEBACK:
  - A write is issued in any cycle where cu_write_out_enable=1 and cu_address differs from last_addr. In that cycle:
    - ram_we=1, ram_addr=cu_address, ram_wdata=cu_output.
    - last_addr updates.
    - ret_cnt increments if cu_output is nonzero.
  - last_addr resets to all-ones on WRITEBACK entry, so address 0 is always written.
  - Repeated addresses are not rewritten.
  - Falling cu_write_out_enable moves to CHECK.
- CHECK (1 cycle):
  - removed = load_cnt - ret_cnt, computed with ADDR_W+1 bit counters.
  - If ret_cnt > load_cnt, removed is treated as 0. Thinning never adds pixels.
  - iter_count increments, saturating at 255.
  - cu_phase toggles.
  - If removed==0 and the zero-pass flag is set: converged=1, go to DONE.
  - Else if removed==0: set the zero-pass flag.
  - Else: clear the zero-pass flag.
  - If not done and iter_count reaches max_iter: go to DONE with converged=0.
  - Otherwise: clear load_cnt and ret_cnt and return to LOAD.
- DONE: busy=0, done=1; state holds until start.
- ram_re and ram_we are never high in the same cycle. The RAM is single-ported.

Test Plan:
- All-zero 8x8 frame, max_iter=10, start pulse -> two passes remove 0; done=1, converged=1, error=0, iter_count=2; cu_phase sequence 0,1.
- Frame with 3x3 solid block, convolution model removing the 8 border pixels on pass 1 and nothing after -> iter_count=3, converged=1; RAM holds the single center pixel; exactly 64 RAM writes per pass.
- Same frame with max_iter=1 -> done after 1 pass, converged=0, iter_count=1.
- Convolution model never asserts write_out_enable, TIMEOUT=16 -> done with error=1 exactly 16 cycles after LOAD ends; no RAM writes.
- Convolution model holds each cu_address for 2 cycles -> one ram_we per address; 64 writes, not 128.
- rst asserted mid-LOAD at word 20, then start again -> outputs all 0 immediately on rst; restart begins at ram_addr 0, iter_count 0.
